// File: rtl/disp_queue_mw.sv
// Multi-lane dispatch queue: circular buffer with compacting all-or-nothing
// enqueue and in-order prefix dequeue.
module disp_queue_mw #(
    parameter int DEPTH      = 16,
    parameter int ENQ_WIDTH  = 4,
    parameter int DEQ_WIDTH  = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_squash,
    output logic                            o_can_enq,
    input  logic [ENQ_WIDTH-1:0]            i_enq_vld,
    input  logic [ENQ_WIDTH*DATA_WIDTH-1:0] i_enq_data,
    output logic [DEQ_WIDTH-1:0]            o_deq_vld,
    output logic [DEQ_WIDTH*DATA_WIDTH-1:0] o_deq_data,
    input  logic [DEQ_WIDTH-1:0]            i_deq_rdy,
    output logic [$clog2(DEPTH):0]          o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [ENQ_WIDTH-1:0][PW-1:0] enq_slot;
    logic [CW-1:0] enq_n, deq_n;
    logic          enq_fire, deq_run;

    // Admission uses only the registered count; same-cycle dequeue earns no credit.
    assign o_can_enq = (count_q <= CW'(DEPTH - ENQ_WIDTH));
    assign enq_fire  = o_can_enq & ~i_squash;
    assign o_count   = count_q;

    // Valid lanes are packed densely starting at tail, in ascending lane order.
    always_comb begin
        enq_n    = '0;
        enq_slot = '0;
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            enq_slot[k] = tail_q + enq_n[PW-1:0];
            if (i_enq_vld[k]) enq_n = enq_n + CW'(1);
        end
    end

    always_comb begin
        o_deq_vld  = '0;
        o_deq_data = '0;
        deq_n      = '0;
        deq_run    = 1'b1;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            o_deq_vld[i] = (CW'(i) < count_q);
            o_deq_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[head_q + PW'(i)];
            // Consumption stops at the first lane that is empty or not ready.
            if (deq_run && o_deq_vld[i] && i_deq_rdy[i]) deq_n = deq_n + CW'(1);
            else deq_run = 1'b0;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + deq_n[PW-1:0];
            tail_d  = o_can_enq ? tail_q + enq_n[PW-1:0] : tail_q;
            count_d = count_q + (o_can_enq ? enq_n : '0) - deq_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload array carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (enq_fire && i_enq_vld[k])
                mem_q[enq_slot[k]] <= i_enq_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: tb/tb_disp_queue_mw.sv
// Directed table-driven bench for disp_queue_mw at DEPTH=8, 4/4 lanes, 8-bit data.
module tb_disp_queue_mw;
    logic        clk, rst, i_squash, o_can_enq;
    logic [3:0]  i_enq_vld, o_deq_vld, i_deq_rdy;
    logic [31:0] i_enq_data, o_deq_data;
    logic [3:0]  o_count;

    int n_chk  = 0;
    int n_fail = 0;

    disp_queue_mw #(.DEPTH(8), .ENQ_WIDTH(4), .DEQ_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .i_squash(i_squash), .o_can_enq(o_can_enq),
        .i_enq_vld(i_enq_vld), .i_enq_data(i_enq_data),
        .o_deq_vld(o_deq_vld), .o_deq_data(o_deq_data),
        .i_deq_rdy(i_deq_rdy), .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ev;
        logic [31:0] ed;
        logic [3:0]  rdy;
        logic        sq;
        logic [3:0]  cnt;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        can;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] v);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (v[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic chk_state(input string tag, input logic [3:0] cnt, input logic [3:0] vld,
                             input logic [31:0] dat, input logic can);
        logic [31:0] m;
        m = lane_mask(vld);
        chk({tag, " count"}, 32'(o_count), 32'(cnt));
        chk({tag, " deq_vld"}, 32'(o_deq_vld), 32'(vld));
        chk({tag, " can_enq"}, 32'(o_can_enq), 32'(can));
        chk({tag, " deq_data"}, o_deq_data & m, dat & m);
    endtask

    initial begin
        //          ev       ed            rdy      sq    cnt   vld      dat           can
        tbl[0]  = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 4'd4, 4'b1111, 32'h13121110, 1'b1};
        tbl[1]  = '{4'b0000, 32'h0,        4'b1111, 1'b0, 4'd0, 4'b0000, 32'h0,        1'b1};
        tbl[2]  = '{4'b1010, 32'hA300A100, 4'b0000, 1'b0, 4'd2, 4'b0011, 32'h0000A3A1, 1'b1};
        tbl[3]  = '{4'b0111, 32'h00C2C1C0, 4'b0000, 1'b0, 4'd5, 4'b1111, 32'hC1C0A3A1, 1'b0};
        tbl[4]  = '{4'b1111, 32'hD3D2D1D0, 4'b1011, 1'b0, 4'd3, 4'b0111, 32'h00C2C1C0, 1'b1};
        tbl[5]  = '{4'b0000, 32'h0,        4'b0001, 1'b0, 4'd2, 4'b0011, 32'h0000C2C1, 1'b1};
        tbl[6]  = '{4'b0000, 32'h0,        4'b1111, 1'b0, 4'd0, 4'b0000, 32'h0,        1'b1};
        tbl[7]  = '{4'b1111, 32'hE3E2E1E0, 4'b0000, 1'b0, 4'd4, 4'b1111, 32'hE3E2E1E0, 1'b1};
        tbl[8]  = '{4'b0001, 32'h000000F0, 4'b1111, 1'b0, 4'd1, 4'b0001, 32'h000000F0, 1'b1};
        tbl[9]  = '{4'b0000, 32'h0,        4'b0001, 1'b0, 4'd0, 4'b0000, 32'h0,        1'b1};
        tbl[10] = '{4'b1111, 32'hB3B2B1B0, 4'b0000, 1'b0, 4'd4, 4'b1111, 32'hB3B2B1B0, 1'b1};
        tbl[11] = '{4'b0000, 32'h0,        4'b1111, 1'b0, 4'd0, 4'b0000, 32'h0,        1'b1};
        tbl[12] = '{4'b1111, 32'h73727170, 4'b0000, 1'b0, 4'd4, 4'b1111, 32'h73727170, 1'b1};
        tbl[13] = '{4'b0011, 32'h00008180, 4'b0000, 1'b0, 4'd6, 4'b1111, 32'h73727170, 1'b0};
        tbl[14] = '{4'b1111, 32'h93929190, 4'b1111, 1'b1, 4'd0, 4'b0000, 32'h0,        1'b1};
        tbl[15] = '{4'b1111, 32'h63626160, 4'b0000, 1'b0, 4'd4, 4'b1111, 32'h63626160, 1'b1};
        tbl[16] = '{4'b0111, 32'h00525150, 4'b0000, 1'b0, 4'd7, 4'b1111, 32'h63626160, 1'b0};

        rst = 1'b0; i_squash = 1'b0; i_enq_vld = '0; i_enq_data = '0; i_deq_rdy = '0;
        #2;
        chk_state("reset", 4'd0, 4'b0000, 32'h0, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 17; v++) begin
            i_enq_vld  = tbl[v].ev;
            i_enq_data = tbl[v].ed;
            i_deq_rdy  = tbl[v].rdy;
            i_squash   = tbl[v].sq;
            @(posedge clk); #1;
            chk_state($sformatf("vec%0d", v), tbl[v].cnt, tbl[v].vld, tbl[v].dat, tbl[v].can);
        end

        // Asynchronous reset between edges while holding 7 entries.
        i_enq_vld = '0; i_deq_rdy = '0; i_squash = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk_state("async_rst", 4'd0, 4'b0000, 32'h0, 1'b1);
        @(negedge clk); rst = 1'b1;

        // Enqueue from empty after reset: nothing visible until the edge.
        i_enq_vld = 4'b1111; i_enq_data = 32'h43424140;
        #1;
        chk("no_bypass deq_vld", 32'(o_deq_vld), 32'h0);
        @(posedge clk); #1;
        i_enq_vld = '0;
        chk_state("post_rst", 4'd4, 4'b1111, 32'h43424140, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/disp_queue_mw.md
DISP_QUEUE_MW -- requirements
Module: disp_queue_mw

Interface
REQ-001 Parameter DEPTH, default 16: entry count; SHALL be a power of two and >= 2*ENQ_WIDTH.
REQ-002 Parameter ENQ_WIDTH, default 4: enqueue lanes per cycle.
REQ-003 Parameter DEQ_WIDTH, default 4: dequeue lanes per cycle; SHALL be <= DEPTH.
REQ-004 Parameter DATA_WIDTH, default 64: packed payload width per entry, for example a packed intDQEntry_t.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low; rst=0 resets all state immediately.
REQ-007 i_squash  input  1  pipeline squash; flushes the queue.
REQ-008 o_can_enq  output  1  queue can accept a full group of ENQ_WIDTH entries.
REQ-009 i_enq_vld  input  ENQ_WIDTH  per-lane enqueue valid; any bit pattern is legal.
REQ-010 i_enq_data  input  ENQ_WIDTH*DATA_WIDTH  lane payloads; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 o_deq_vld  output  DEQ_WIDTH  per-lane dequeue valid.
REQ-012 o_deq_data  output  DEQ_WIDTH*DATA_WIDTH  lane payloads; lane 0 is the oldest entry.
REQ-013 i_deq_rdy  input  DEQ_WIDTH  per-lane consumer ready.
REQ-014 o_count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 The queue SHALL be a circular buffer with head and tail pointers of width clog2(DEPTH); both pointers SHALL wrap modulo DEPTH.
REQ-016 o_can_enq SHALL be 1 iff (DEPTH - o_count) >= ENQ_WIDTH, computed from the registered count with no credit for same-cycle dequeue.
REQ-017 Enqueue SHALL be all-or-nothing: when o_can_enq=1, all lanes with i_enq_vld set are written; when o_can_enq=0, every lane is dropped.
REQ-018 Valid enqueue lanes SHALL be compacted in ascending lane order into tail, tail+1, ...; tail SHALL advance by popcount(i_enq_vld).
REQ-019 o_deq_vld[i] SHALL be 1 iff i < o_count; o_deq_data lane i SHALL be storage[head+i mod DEPTH], read combinationally.
REQ-020 The dequeue count SHALL be the largest n such that o_deq_vld[j] and i_deq_rdy[j] are both 1 for every j < n; no lane after a not-ready lane is consumed, and head SHALL advance by n.
REQ-021 The count SHALL update as count + enq_n - deq_n in one cycle; simultaneous enqueue and dequeue are both honoured.
REQ-022 An entry enqueued in cycle t SHALL be visible on o_deq_* no earlier than cycle t+1; there is no bypass path.
REQ-023 When i_squash=1 at a clock edge, head, tail and count SHALL become 0, and any enqueue or dequeue in that cycle SHALL be discarded.
REQ-024 Payload storage SHALL NOT be reset; only pointers and count are reset.
REQ-025 The count SHALL never exceed DEPTH and never go below 0 under any legal input.

Reset
REQ-026 While rst=0: head=0, tail=0, o_count=0, o_deq_vld=0, o_can_enq=1.
REQ-027 A reset asserted mid-operation SHALL discard all contents asynchronously; after rst is released, the first edge SHALL behave as from empty.

Verification (DEPTH=8, ENQ_WIDTH=4, DEQ_WIDTH=4, DATA_WIDTH=8)
REQ-028 Reset, then i_enq_vld=4'b1111 with data 0x10..0x13, i_deq_rdy=0 -> next cycle o_count=4, o_deq_vld=4'b1111, lanes 0..3 = 0x10..0x13, o_can_enq=1.
REQ-029 Enqueue i_enq_vld=4'b1010 with data lane1=0xA1, lane3=0xA3, into an empty queue -> o_count=2, lane0=0xA1, lane1=0xA3.
REQ-030 Fill to count=5, then offer 4 entries -> o_can_enq=0, all lanes dropped, count stays 5; in the same cycle i_deq_rdy=4'b1011 -> 2 entries dequeued, count=3.
REQ-031 Wrap-around: with head=6 and count=0, enqueue 4 entries 0xB0..0xB3 -> stored at slots 6,7,0,1; dequeue of all 4 yields 0xB0..0xB3 in order, then head=2.
REQ-032 With count=6, assert i_squash together with a 4-lane enqueue and full dequeue-ready -> next cycle o_count=0, o_deq_vld=0, o_can_enq=1.
REQ-033 Assert rst=0 asynchronously between edges while count=7 -> o_count=0 and o_deq_vld=0 immediately, before the next edge.
